instr_encoder: RTL and testbench

Program loader for the single-cycle MIPS core. It accepts symbolic instructions (mnemonic plus register/immediate fields) over a valid/ready stream and packs each one into a 32-bit MIPS word. It writes the words sequentially into instruction memory and holds the core in reset until the program is loaded. It is the encoding counterpart of the core's op/funct control decode: every word it emits must decode back to the same operation.

---
 rtl/instr_encoder.sv | 139 +++++++++++++
 tb/tb_instr_encoder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Program loader for the single-cycle MIPS core: packs symbolic instructions into
// 32-bit words, writes them sequentially to instruction memory, then releases the core.
module instr_encoder #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          s_last,
  input  logic [3:0]    mnem,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [4:0]    shamt,
  input  logic [15:0]   imm,
  input  logic [25:0]   target,
  input  logic          restart,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_run,
  output logic [AW:0]   count,
  output logic          err
);

  typedef enum logic [3:0] {
    MN_NOP  = 4'd0,
    MN_ADD  = 4'd1,
    MN_SUB  = 4'd2,
    MN_AND  = 4'd3,
    MN_OR   = 4'd4,
    MN_SLT  = 4'd5,
    MN_SLL  = 4'd6,
    MN_LW   = 4'd7,
    MN_SW   = 4'd8,
    MN_BEQ  = 4'd9,
    MN_ADDI = 4'd10,
    MN_J    = 4'd11
  } mnem_e;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state;
  logic        last_q;
  logic        legal;
  logic [31:0] word;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    legal = 1'b1;
    word  = '0;
    case (mnem_e'(mnem))
      MN_NOP:  word = '0;
      MN_ADD:  word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      MN_SUB:  word = {6'h00, rs, rt, rd, 5'd0, 6'h22};
      MN_AND:  word = {6'h00, rs, rt, rd, 5'd0, 6'h24};
      MN_OR:   word = {6'h00, rs, rt, rd, 5'd0, 6'h25};
      MN_SLT:  word = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      MN_SLL:  word = {6'h00, 5'd0, rt, rd, shamt, 6'h00};
      MN_LW:   word = {6'h23, rs, rt, imm};
      MN_SW:   word = {6'h2B, rs, rt, imm};
      MN_BEQ:  word = {6'h04, rs, rt, imm};
      MN_ADDI: word = {6'h08, rs, rt, imm};
      MN_J:    word = {6'h02, target};
      default: legal = 1'b0;
    endcase
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      s_ready    <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_run    <= 1'b0;
      count      <= '0;
      err        <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (s_valid) begin
            if (legal) begin
              state      <= WRITE;
              s_ready    <= 1'b0;
              imem_we    <= 1'b1;
              imem_addr  <= count[AW-1:0];
              imem_wdata <= word;
              last_q     <= s_last;
            end else begin
              // Illegal beats are dropped without a write; only the last flag matters.
              err <= 1'b1;
              if (s_last) begin
                state   <= DONE;
                s_ready <= 1'b0;
                cpu_run <= 1'b1;
              end
            end
          end
        end
        WRITE: begin
          imem_we <= 1'b0;
          count   <= count + (AW+1)'(1);
          if (last_q || (&imem_addr)) begin
            state   <= DONE;
            cpu_run <= 1'b1;
          end else begin
            state   <= LOAD;
            s_ready <= 1'b1;
          end
        end
        DONE: begin
          if (restart) begin
            state   <= LOAD;
            s_ready <= 1'b1;
            cpu_run <= 1'b0;
            count   <= '0;
            err     <= 1'b0;
          end
        end
        default: begin
          state   <= LOAD;
          s_ready <= 1'b1;
          imem_we <= 1'b0;
          cpu_run <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: two instances (AW=6 and AW=2) share stimulus and
// are compared every cycle against a transaction-level model, plus literal encodings.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [3:0]  mnem = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic        restart = 1'b0;

  logic        rdy6, we6, run6, err6;
  logic [5:0]  addr6;
  logic [31:0] wdata6;
  logic [6:0]  cnt6;

  logic        rdy2, we2, run2, err2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [2:0]  cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_encoder #(.AW(6)) dut6 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(rdy6), .s_last(s_last),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
    .restart(restart), .imem_we(we6), .imem_addr(addr6), .imem_wdata(wdata6),
    .cpu_run(run6), .count(cnt6), .err(err6)
  );

  instr_encoder #(.AW(2)) dut2 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(rdy2), .s_last(s_last),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
    .restart(restart), .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
    .cpu_run(run2), .count(cnt2), .err(err2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding rules as field arithmetic; returns {legal, word}.
  int r_funct [6]  = '{0, 'h20, 'h22, 'h24, 'h25, 'h2A};
  int i_op    [12] = '{0, 0, 0, 0, 0, 0, 0, 'h23, 'h2B, 'h04, 'h08, 0};

  function automatic logic [32:0] model_enc(int mn, int f_rs, int f_rt, int f_rd, int f_sh,
                                            int f_imm, int f_tgt);
    logic [31:0] w;
    w = 0;
    if (mn == 0) return {1'b1, 32'h0};
    if (mn >= 1 && mn <= 5) begin
      w = f_rs * 32'h0020_0000 + f_rt * 32'h0001_0000 + f_rd * 32'h0000_0800 + r_funct[mn];
      return {1'b1, w};
    end
    if (mn == 6) begin
      w = f_rt * 32'h0001_0000 + f_rd * 32'h0000_0800 + f_sh * 32'h40;
      return {1'b1, w};
    end
    if (mn >= 7 && mn <= 10) begin
      w = i_op[mn] * 32'h0400_0000 + f_rs * 32'h0020_0000 + f_rt * 32'h0001_0000 + f_imm;
      return {1'b1, w};
    end
    if (mn == 11) return {1'b1, 32'h0800_0000 + f_tgt};
    return {1'b0, 32'h0};
  endfunction

  // Per-instance model state: index 0 is AW=6 (64 words), index 1 is AW=2 (4 words).
  int          depth [2] = '{64, 4};
  bit          m_busy [2], m_done [2], m_lastp [2], m_err [2];
  int          m_count [2], m_addr [2];
  logic [31:0] m_wdata [2];
  bit          model_on = 1'b0;

  always @(posedge clk) begin
    logic [32:0] e;
    e = model_enc(mnem, rs, rt, rd, shamt, imm, target);
    if (reset) model_on = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_busy[k] = 0; m_done[k] = 0; m_lastp[k] = 0; m_err[k] = 0;
        m_count[k] = 0; m_addr[k] = 0; m_wdata[k] = 0;
      end else if (m_busy[k]) begin
        m_busy[k] = 0;
        m_count[k]++;
        if (m_lastp[k] || m_count[k] == depth[k]) m_done[k] = 1;
      end else if (m_done[k]) begin
        if (restart) begin
          m_done[k] = 0; m_count[k] = 0; m_err[k] = 0;
        end
      end else if (s_valid) begin
        if (e[32]) begin
          m_busy[k] = 1; m_addr[k] = m_count[k]; m_wdata[k] = e[31:0]; m_lastp[k] = s_last;
        end else begin
          m_err[k] = 1;
          if (s_last) m_done[k] = 1;
        end
      end
    end
  end

  logic [31:0] mem6 [64];
  logic [31:0] mem2 [4];
  logic [31:0] sb_q [$];

  // Single compare process: cycle-level outputs of both instances, plus the write scoreboard.
  always @(negedge clk) begin
    if (model_on) begin
      check("ready6", rdy6,   !m_busy[0] && !m_done[0]);
      check("we6",    we6,    m_busy[0]);
      check("run6",   run6,   m_done[0]);
      check("err6",   err6,   m_err[0]);
      check("count6", cnt6,   m_count[0]);
      check("addr6",  addr6,  m_addr[0]);
      check("wdata6", wdata6, m_wdata[0]);
      check("ready2", rdy2,   !m_busy[1] && !m_done[1]);
      check("we2",    we2,    m_busy[1]);
      check("run2",   run2,   m_done[1]);
      check("err2",   err2,   m_err[1]);
      check("count2", cnt2,   m_count[1]);
      check("addr2",  addr2,  m_addr[1][1:0]);
      check("wdata2", wdata2, m_wdata[1]);
    end
    if (we6 === 1'b1) begin
      mem6[addr6] = wdata6;
      check("sb_write_expected", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) check("sb_word", wdata6, sb_q.pop_front());
    end
    if (we2 === 1'b1) mem2[addr2] = wdata2;
  end

  // Present one beat and hold it until the AW=6 instance accepts; s_valid stays high after.
  task automatic send(input int mn, input int a_rs, input int a_rt, input int a_rd,
                      input int a_sh, input int a_imm, input int a_tgt, input bit last);
    logic [32:0] e;
    int waited;
    mnem = mn[3:0]; rs = a_rs[4:0]; rt = a_rt[4:0]; rd = a_rd[4:0]; shamt = a_sh[4:0];
    imm = a_imm[15:0]; target = a_tgt[25:0]; s_last = last; s_valid = 1'b1;
    e = model_enc(mn, a_rs, a_rt, a_rd, a_sh, a_imm, a_tgt);
    waited = 0;
    @(negedge clk);
    while (rdy6 !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (rdy6 !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: s_ready stayed %b for mnem %0d", rdy6, mn);
    end else begin
      @(posedge clk);
      #1;
      if (e[32]) sb_q.push_back(e[31:0]);
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset   = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] e;

    // Pin the model against hand-computed encodings.
    e = model_enc(1, 1, 2, 3, 0, 0, 0);       check("enc_add",  e[31:0], 32'h0022_1820);
    e = model_enc(7, 0, 4, 0, 0, 8, 0);       check("enc_lw",   e[31:0], 32'h8C04_0008);
    e = model_enc(11, 0, 0, 0, 0, 0, 'h10);   check("enc_j",    e[31:0], 32'h0800_0010);
    e = model_enc(6, 7, 5, 2, 4, 0, 0);       check("enc_sll",  e[31:0], 32'h0005_1100);
    e = model_enc(9, 1, 2, 0, 0, 'hFFFF, 0);  check("enc_beq",  e[31:0], 32'h1022_FFFF);
    e = model_enc(8, 3, 4, 0, 0, 'h20, 0);    check("enc_sw",   e[31:0], 32'hAC64_0020);
    e = model_enc(13, 1, 2, 3, 4, 5, 6);      check("enc_illegal_flag", e[32], 1'b0);

    do_reset(2);
    check("rst_ready", rdy6, 1);
    check("rst_we",    we6, 0);
    check("rst_addr",  addr6, 0);
    check("rst_wdata", wdata6, 0);
    check("rst_run",   run6, 0);
    check("rst_count", cnt6, 0);
    check("rst_err",   err6, 0);

    // Three-beat program ending in a jump.
    send(1, 1, 2, 3, 0, 0, 0, 0);   idle(1);
    send(7, 0, 4, 0, 0, 8, 0, 0);   idle(1);
    send(11, 0, 0, 0, 0, 0, 'h10, 1);
    idle(3);
    check("prog_mem0",  mem6[0], 32'h0022_1820);
    check("prog_mem1",  mem6[1], 32'h8C04_0008);
    check("prog_mem2",  mem6[2], 32'h0800_0010);
    check("prog_count", cnt6, 3);
    check("prog_run",   run6, 1);
    check("prog_ready", rdy6, 0);

    // SLL ignores rs; BEQ keeps a negative offset.
    do_restart();
    send(6, 7, 5, 2, 4, 0, 0, 0);
    send(9, 1, 2, 0, 0, 'hFFFF, 0, 1);
    idle(3);
    check("sll_mem0", mem6[0], 32'h0005_1100);
    check("beq_mem1", mem6[1], 32'h1022_FFFF);

    // Illegal mnemonic between two legal beats leaves no gap.
    do_restart();
    send(1, 2, 3, 1, 0, 0, 0, 0);
    send(13, 9, 9, 9, 9, 9, 9, 0);
    send(4, 4, 5, 6, 0, 0, 0, 1);
    idle(3);
    check("ill_mem0",  mem6[0], 32'h0043_0820);
    check("ill_mem1",  mem6[1], 32'h0085_3025);
    check("ill_err",   err6, 1);
    check("ill_count", cnt6, 2);
    do_restart();
    check("restart_err",   err6, 0);
    check("restart_count", cnt6, 0);
    check("restart_ready", rdy6, 1);

    // Continuous valid; the AW=2 instance fills after four words and refuses the fifth.
    do_reset(1);
    for (int k = 1; k <= 5; k++) send(10, k, k + 1, 0, 0, 16 * k + 1, 0, 0);
    idle(3);
    check("full_mem2_0", mem2[0], 32'h2022_0011);
    check("full_mem2_3", mem2[3], 32'h2085_0041);
    check("full_count2", cnt2, 4);
    check("full_run2",   run2, 1);
    check("full_ready2", rdy2, 0);
    check("full_count6", cnt6, 5);
    check("full_mem6_4", mem6[4], 32'h20A6_0051);

    // Reset during the WRITE cycle of the second word abandons it.
    do_reset(1);
    send(8, 3, 4, 0, 0, 'h20, 0, 0);
    send(1, 5, 6, 7, 0, 0, 0, 0);
    do_reset(1);
    check("midrst_we",    we6, 0);
    check("midrst_count", cnt6, 0);
    check("midrst_ready", rdy6, 1);
    check("midrst_wdata", wdata6, 0);
    send(1, 1, 2, 3, 0, 0, 0, 1);
    idle(3);
    check("reload_mem0",  mem6[0], 32'h0022_1820);
    check("reload_count", cnt6, 1);
    check("reload_run",   run6, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
